// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU stage: op encodings, FSM states, default width.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_XOR = 3'b010,
    OP_NOR = 3'b011,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101,
    OP_SLT = 3'b110,
    OP_MUL = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    MUL_RUN,
    DONE
  } alu_state_t;

endpackage

// File: rtl/shift_add_mul_core.sv
// Shift-add multiplier: WIDTH iterations after start_i, no early exit; low WIDTH product bits.
// done_o is high for the one cycle in which product_o (the final accumulate) is valid.
module shift_add_mul_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] acc_sum;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  always_comb begin
    acc_sum  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_o   = 1'b0;
    if (start_i) begin
      mcand_d  = a_i;
      mplier_d = b_i;
      acc_d    = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      acc_d    = acc_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      // The last iteration's sum is handed out combinationally so the top can register it this edge.
      if (cnt_q == CNT_W'(WIDTH - 1)) begin
        busy_d = 1'b0;
        done_o = 1'b1;
      end
    end
  end

  assign product_o = acc_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: rtl/alu_seq_unit.sv
// Registered valid/ready ALU stage; logic ops/ADD/SUB/SLT in 1 cycle, MUL in WIDTH+1; result held while !out_ready.
// Define ALU_SEQ_STATUS_FLAGS_EN to add registered zero/ovf outputs.
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
`ifdef ALU_SEQ_STATUS_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  alu_state_t       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] sum, diff;
  logic [WIDTH-1:0] mul_product;
  logic             mul_done;
  logic             accept;
  logic             mul_start;
  alu_op_t          op;

  assign op        = alu_op_t'(alu_op);
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op == OP_MUL);
  assign sum       = a + b;
  assign diff      = a - b;

  always_comb begin
    alu_res = '0;
    case (op)
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_NOR: alu_res = ~(a | b);
      OP_ADD: alu_res = sum;
      OP_SUB: alu_res = diff;
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_MUL: alu_res = '0;
    endcase
  end

  shift_add_mul_core #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (mul_start),
    .a_i       (a),
    .b_i       (b),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

`ifdef ALU_SEQ_STATUS_FLAGS_EN
  logic zero_q, zero_d;
  logic ovf_q, ovf_d;
  logic ovf_now;

  always_comb begin
    ovf_now = 1'b0;
    if (op == OP_ADD)
      ovf_now = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    else if (op == OP_SUB)
      ovf_now = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
  end

  assign zero = zero_q;
  assign ovf  = ovf_q;
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
`ifdef ALU_SEQ_STATUS_FLAGS_EN
    zero_d   = zero_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (op == OP_MUL) begin
            state_d = MUL_RUN;
          end else begin
            state_d  = DONE;
            result_d = alu_res;
`ifdef ALU_SEQ_STATUS_FLAGS_EN
            zero_d   = (alu_res == '0);
            ovf_d    = ovf_now;
`endif
          end
        end
      end
      MUL_RUN: begin
        if (mul_done) begin
          state_d  = DONE;
          result_d = mul_product;
`ifdef ALU_SEQ_STATUS_FLAGS_EN
          zero_d   = (mul_product == '0);
          ovf_d    = 1'b0;
`endif
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
`ifdef ALU_SEQ_STATUS_FLAGS_EN
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
`ifdef ALU_SEQ_STATUS_FLAGS_EN
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Scoreboard bench for alu_seq_unit: directed corner cases plus randomized traffic against an arithmetic model.
module tb_alu_seq_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [2:0]  alu_op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] result;
`ifdef ALU_SEQ_STATUS_FLAGS_EN
  logic        zero;
  logic        ovf;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rise_cyc = 0;
  bit prev_valid = 1'b0;
  bit rand_rdy = 1'b0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] res;
    int          acc_cyc;
  } exp_t;

  exp_t sbq[$];

  alu_seq_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef ALU_SEQ_STATUS_FLAGS_EN
    .zero      (zero),
    .ovf       (ovf),
`endif
    .result    (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    case (op)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return x ^ y;
      3'd3: return ~(x | y);
      3'd4: return x + y;
      3'd5: return x - y;
      3'd6: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      default: begin
        p = {32'd0, x} * {32'd0, y};
        return p[31:0];
      end
    endcase
  endfunction

  function automatic logic model_ovf(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    longint s;
    if (op == 3'd4)      s = longint'($signed(x)) + longint'($signed(y));
    else if (op == 3'd5) s = longint'($signed(x)) - longint'($signed(y));
    else                 return 1'b0;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per completed output handshake.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && out_valid && !prev_valid) rise_cyc = cyc;
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got result 0x%08h, expected no output", result);
      end else begin
        e = sbq.pop_front();
        check("result", result, e.res);
        check("latency", 32'(rise_cyc - e.acc_cyc + 1), (e.op == 3'd7) ? 32'd33 : 32'd1);
`ifdef ALU_SEQ_STATUS_FLAGS_EN
        check("zero_flag", {31'd0, zero}, {31'd0, (e.res == 32'd0)});
        check("ovf_flag", {31'd0, ovf}, {31'd0, model_ovf(e.op, e.x, e.y)});
`endif
      end
    end
    prev_valid = rst_n && out_valid;
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    int n;
    exp_t e;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 200 cycles");
      return;
    end
    in_valid = 1'b1;
    alu_op   = op;
    a        = x;
    b        = y;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    alu_op   = 3'($urandom);
    a        = $urandom;
    b        = $urandom;
    e.op      = op;
    e.x       = x;
    e.y       = y;
    e.res     = model(op, x, y);
    e.acc_cyc = cyc;
    sbq.push_back(e);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_result", result, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

    // NOR corners
    send(3'd3, 32'h0000_0000, 32'h0000_0000);
    check("nor_valid_1cyc", {31'd0, out_valid}, 32'd1);
    check("nor_zero_result", result, 32'hFFFF_FFFF);
    send(3'd3, 32'hF0F0_F0F0, 32'h0F0F_0000);

    // ADD wrap / overflow, SLT both orders
    send(3'd4, 32'hFFFF_FFFF, 32'h0000_0001);
    send(3'd4, 32'h7FFF_FFFF, 32'h0000_0001);
    send(3'd6, 32'hFFFF_FFFF, 32'h0000_0001);
    send(3'd6, 32'h0000_0001, 32'hFFFF_FFFF);

    // MUL with ignored in_valid pulses while busy
    send(3'd7, 32'h0000_1234, 32'h0000_0010);
    for (int i = 1; i <= 31; i++) begin
      @(posedge clk);
      #1;
      check("mul_in_ready_low", {31'd0, in_ready}, 32'd0);
      check("mul_out_valid_low", {31'd0, out_valid}, 32'd0);
      in_valid = (i % 3 == 0);
      alu_op   = 3'($urandom);
    end
    in_valid = 1'b0;
    wait_drain();

    // Backpressure: hold the result for 5 cycles
    out_ready = 1'b0;
    send(3'd4, 32'h0000_0005, 32'h0000_0007);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_result", result, 32'd12);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
    send(3'd2, 32'hDEAD_BEEF, 32'h1234_5678);
    wait_drain();

    // Asynchronous reset mid-MUL
    send(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    sbq.delete();
    #1;
    check("rst_mid_mul_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_mul_result", result, 32'd0);
    check("rst_mid_mul_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(3'd0, 32'hFF00_FF00, 32'h0FF0_0FF0);
    wait_drain();
    repeat (40) @(posedge clk);
    #1;

    // Randomized traffic with random downstream stalls
    rand_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      send(3'($urandom_range(0, 7)), pick(), pick());
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain();
    repeat (5) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq_unit.md
Name: alu_seq_unit

Overview:
- Registered, handshaked ALU stage that consumes 32-bit operand pairs and produces one registered result per transaction.
- Covers bitwise AND/OR/XOR/NOR, ADD/SUB/SLT, and a multi-cycle shift-add MUL.
- Sits between the operand/decode stage (upstream, valid/ready) and the writeback stage (downstream, valid/ready).
- Replaces bare combinational result wiring with a clean cycle boundary and backpressure.

Parameters:
- WIDTH, 32, operand and result width in bits (WIDTH >= 2).
- CNT_W, $clog2(WIDTH), width of the multiply iteration counter (derived, not overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and op presented.
- in_ready  output  1  unit can accept; high only in IDLE.
- alu_op  input  3  operation select (encodings in package).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result register holds a valid result.
- out_ready  input  1  downstream accepts result.
- result  output  WIDTH  registered result.

Behaviour:
- Op encodings: 000 AND, 001 OR, 010 XOR, 011 NOR (~(a|b)), 100 ADD, 101 SUB, 110 SLT, 111 MUL. All 8 codes are legal.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^WIDTH.
  - SLT is a signed compare; result = {WIDTH-1 zeros, (a<b signed)}.
  - MUL returns the low WIDTH bits of the unsigned product (equal to the signed low half).
- States:
  - IDLE: in_ready=1, out_valid=0.
  - MUL_RUN: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Accept condition: in_valid && in_ready, sampled on the rising edge.
- IDLE transitions:
  - Accept with op != MUL: result is registered that edge; next state DONE; latency 1 cycle.
  - Accept with op == MUL: load mcand=a, mplier=b, acc=0, cnt=0; next state MUL_RUN.
- MUL_RUN, each cycle:
  - If mplier[0], acc += mcand (mod 2^WIDTH).
  - mcand <<= 1; mplier >>= 1; cnt++.
  - At cnt==WIDTH-1: result <= final acc, go to DONE.
  - Fixed WIDTH iterations; no early exit. Latency WIDTH+1 cycles from accept to out_valid (33 at default).
- DONE: result held stable while out_valid && !out_ready. On out_ready, go to IDLE; in_ready rises the next cycle.
- Throughput: 1 transaction per 2 cycles for single-cycle ops (no accept in the same cycle as drain).
- in_valid while in_ready=0 is ignored; upstream holds its data.
- alu_op, a and b are don't-care unless in_valid && in_ready.
- Reset, asynchronous, any state including mid-MUL:
  - state=IDLE, result=0, out_valid=0, mul registers=0, cnt=0. Any in-flight op is discarded.
  - in_ready=1 once rst_n is deasserted.
- Operand edge cases: a=b=0 gives NOR = all ones. MUL by 0 still takes the full latency.

Optional Feature:
- Macro: ALU_SEQ_STATUS_FLAGS_EN.
- When defined, adds outputs zero (1 bit) and ovf (1 bit), registered with result and held in DONE:
  - zero = (result == 0).
  - ovf = signed overflow for ADD/SUB, 0 for all other ops.
  - Both reset to 0.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package alu_pkg holds:
  - alu_op_t enum with the 3-bit encodings above.
  - alu_state_t enum {IDLE, MUL_RUN, DONE}.
  - ALU_WIDTH = 32 default constant.
- One sub-module: shift_add_mul_core.
  - Holds the mcand/mplier/acc/cnt datapath.
  - Interface: start/done handshake; done asserted for the single cycle the final product is valid.
- The top module owns the FSM, single-cycle op mux, result register and valid/ready logic.

Test Plan:
- Reset then NOR a=0x0000_0000, b=0x0000_0000 → 1 cycle later out_valid=1, result=0xFFFF_FFFF. Then NOR a=0xF0F0_F0F0, b=0x0F0F_0000 → 0x0000_0F0F.
- ADD 0xFFFF_FFFF+0x0000_0001 → 0x0000_0000 (wrap); with flags: zero=1, ovf=0. ADD 0x7FFF_FFFF+1 → 0x8000_0000, ovf=1.
- SLT a=0xFFFF_FFFF (-1), b=0x0000_0001 → 0x0000_0001; swapped operands → 0x0000_0000.
- MUL 0x0000_1234 × 0x0000_0010 → out_valid exactly 33 cycles after accept, result=0x0001_2340; in_ready=0 throughout, and in_valid pulses during MUL_RUN are ignored.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → result and out_valid stable, in_ready=0. Release → IDLE next cycle, next op accepted.
- Assert rst_n=0 at cycle 10 of MUL 0xFFFF_FFFF × 0xFFFF_FFFF → out_valid=0, result=0 immediately. After release, AND 0xFF00_FF00 & 0x0FF0_0FF0 → 0x0F00_0F00 with no stale MUL result emitted.
